conv3x3_stream_filter: RTL and testbench

- Streaming 3x3 image-filter engine and parametrised successor to the fixed single-window sharpening block.
- Accepts a raster-order pixel stream, holds two line buffers plus a 3x3 window, and applies one of four selectable kernels.
- Emits clamped results for every fully populated ("valid-region") window under valid/ready flow control, with end-of-frame signalling.
- Sits between the pixel source (frame reader) and the output frame store.

---
 rtl/conv3x3_stream_filter.sv | 187 ++++++++++++++++++
 tb/tb_conv3x3_stream_filter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_stream_filter.sv
// Streaming 3x3 convolution filter: two line buffers, a 3x3 window, four kernels,
// two-stage multiply/accumulate pipeline with clamped output and end-of-frame flags.
module conv3x3_stream_filter #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 512,
    parameter int IMG_H = 512,
    parameter int ACC_W = PIX_W + 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [PIX_W-1:0] in_pixel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [PIX_W-1:0] out_pixel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             done,
    output logic             busy
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);
    localparam logic signed [ACC_W-1:0] MAX_PIX = ACC_W'((1 << PIX_W) - 1);

    logic [CW-1:0]           r_col;
    logic [RW-1:0]           r_row;
    logic [1:0]              r_mode;
    logic [PIX_W-1:0]        r_lb0 [IMG_W];
    logic [PIX_W-1:0]        r_lb1 [IMG_W];
    logic [PIX_W-1:0]        r_win [3][3];
    logic [PIX_W-1:0]        w_win_next [3][3];
    logic signed [ACC_W-1:0] w_row_sum [3];
    logic signed [ACC_W-1:0] r_s1_row [3];
    logic                    r_s1_valid;
    logic                    r_s1_last;
    logic                    r_s1_gauss;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] w_scaled;
    logic [PIX_W-1:0]        w_clamped;
    logic [PIX_W-1:0]        r_out_pixel;
    logic                    r_out_valid;
    logic                    r_out_last;
    logic                    r_done;
    logic                    r_busy;
    logic                    w_adv;
    logic                    w_accept;
    logic                    w_complete;
    logic                    w_last_pos;
    logic                    w_out_hs;

    // Handshake: input transfers on in_valid & in_ready; output transfers on
    // out_valid & out_ready while enable is high (enable low freezes both sides).
    assign w_adv      = enable & ~reset & (out_ready | ~r_out_valid);
    assign w_accept   = in_valid & w_adv;
    assign w_out_hs   = r_out_valid & out_ready & enable;
    assign w_complete = (r_row >= RW'(2)) && (r_col >= CW'(2));
    assign w_last_pos = (r_row == LAST_ROW) && (r_col == LAST_COL);

    assign in_ready  = w_adv;
    assign out_pixel = r_out_pixel;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign done      = r_done;
    assign busy      = r_busy;

    function automatic logic signed [ACC_W-1:0] coef(input logic [1:0] m, input int rr, input int cc);
        int  k;
        logic ctr;
        logic orth;
        ctr  = (rr == 1) && (cc == 1);
        orth = (rr == 1) != (cc == 1);
        case (m)
            2'd0:    k = ctr ? 1 : 0;
            2'd1:    k = ctr ? 5 : (orth ? -1 : 0);
            2'd2:    k = (rr == 1 ? 2 : 1) * (cc == 1 ? 2 : 1);
            default: k = ctr ? 4 : (orth ? -1 : 0);
        endcase
        return ACC_W'(k);
    endfunction

    always_comb begin
        for (int rr = 0; rr < 3; rr++) begin
            w_win_next[rr][0] = r_win[rr][1];
            w_win_next[rr][1] = r_win[rr][2];
        end
        w_win_next[0][2] = r_lb1[r_col];
        w_win_next[1][2] = r_lb0[r_col];
        w_win_next[2][2] = in_pixel;
    end

    always_comb begin
        for (int rr = 0; rr < 3; rr++) begin
            w_row_sum[rr] = '0;
            for (int cc = 0; cc < 3; cc++) begin
                w_row_sum[rr] = w_row_sum[rr] + coef(r_mode, rr, cc) *
                                $signed({{(ACC_W-PIX_W){1'b0}}, w_win_next[rr][cc]});
            end
        end
    end

    always_comb begin
        w_sum    = r_s1_row[0] + r_s1_row[1] + r_s1_row[2];
        w_scaled = r_s1_gauss ? (w_sum >>> 4) : w_sum;
        if (w_scaled < 0) begin
            w_clamped = '0;
        end else if (w_scaled > MAX_PIX) begin
            w_clamped = '1;
        end else begin
            w_clamped = w_scaled[PIX_W-1:0];
        end
    end

    // Line buffers and window need no reset: row/col gating masks stale contents.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int rr = 0; rr < 3; rr++) begin
                for (int cc = 0; cc < 3; cc++) begin
                    r_win[rr][cc] <= w_win_next[rr][cc];
                end
            end
            r_lb1[r_col] <= r_lb0[r_col];
            r_lb0[r_col] <= in_pixel;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_gauss <= 1'b0;
            for (int rr = 0; rr < 3; rr++) begin
                r_s1_row[rr] <= '0;
            end
        end else if (w_adv) begin
            r_s1_valid <= w_accept & w_complete;
            r_s1_last  <= w_accept & w_last_pos;
            r_s1_gauss <= (r_mode == 2'd2);
            for (int rr = 0; rr < 3; rr++) begin
                r_s1_row[rr] <= w_row_sum[rr];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_col       <= '0;
            r_row       <= '0;
            r_mode      <= 2'd0;
            r_out_pixel <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            if (w_accept) begin
                if (r_row == '0 && r_col == '0) begin
                    r_mode <= mode;
                end
                if (r_col == LAST_COL) begin
                    r_col <= '0;
                    r_row <= (r_row == LAST_ROW) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
            if (w_adv) begin
                r_out_valid <= r_s1_valid;
                r_out_last  <= r_s1_valid & r_s1_last;
                if (r_s1_valid) begin
                    r_out_pixel <= w_clamped;
                end
            end
            r_done <= w_out_hs & r_out_last;
            if (w_accept) begin
                r_busy <= 1'b1;
            end else if (w_out_hs & r_out_last) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv3x3_stream_filter.sv
// Directed bench for conv3x3_stream_filter on an 8x8 image: flat, spike, ramp,
// counting-with-stalls and reset-mid-frame frames against hand-derived expectations.
module tb_conv3x3_stream_filter;

    localparam int PW = 8;
    localparam int W  = 8;
    localparam int H  = 8;
    localparam int NOUT = (W - 2) * (H - 2);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b1;
    logic [1:0]    mode = 2'd0;
    logic [PW-1:0] in_pixel = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [PW-1:0] out_pixel;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_last;
    logic          done;
    logic          busy;

    conv3x3_stream_filter #(.PIX_W(PW), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode),
        .in_pixel(in_pixel), .in_valid(in_valid), .in_ready(in_ready),
        .out_pixel(out_pixel), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int frame_outs = 0;
    int done_cnt = 0;
    int first_valid_cyc = -1;
    int acc_cyc = 0;
    bit rand_ready = 1'b0;
    bit ignore_out = 1'b0;
    logic [PW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [PW-1:0] pix(input int t, input int r, input int c);
        case (t)
            1: return 8'd100;
            2: return (r == 3 && c == 3) ? 8'd200 : 8'd100;
            3: return (r == 4 && c == 4) ? 8'd0 : 8'd255;
            4: return 8'(16 * c);
            5: return 8'(r * 8 + c);
            default: return 8'd50;
        endcase
    endfunction

    // Expected output for the window centred at (r,c), derived by hand per frame.
    function automatic logic [PW-1:0] expv(input int t, input int r, input int c);
        int d;
        d = ((r > 3) ? r - 3 : 3 - r) + ((c > 3) ? c - 3 : 3 - c);
        case (t)
            1: return 8'd100;
            2: return (d == 0) ? 8'd255 : ((d == 1) ? 8'd0 : 8'd100);
            3: return (r == 4 && c == 4) ? 8'd0 : 8'd255;
            4: return 8'(16 * c);
            5: return 8'(r * 8 + c);
            default: return 8'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        #1 out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    logic          prev_stall = 1'b0;
    logic [PW-1:0] prev_pix = '0;
    logic          prev_last = 1'b0;
    logic          hs;
    logic [PW-1:0] e;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_pix", out_pixel, prev_pix);
                check("stall_valid", out_valid, 1);
                check("stall_last", out_last, prev_last);
            end
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            hs = out_valid & out_ready & enable;
            if (hs && !ignore_out) begin
                frame_outs++;
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("pix", out_pixel, e);
                end
                check("last", out_last, frame_outs == NOUT);
            end
            if (done) done_cnt++;
            prev_stall = out_valid & ~hs;
            prev_pix   = out_pixel;
            prev_last  = out_last;
        end
    end

    task automatic send_pixel(input logic [PW-1:0] p);
        bit acc;
        int guard;
        in_pixel = p;
        in_valid = 1'b1;
        acc = 1'b0;
        guard = 0;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
            if (guard > 1000) begin
                $display("FAIL accept_timeout got=0 exp=1");
                $fatal(1, "input never accepted");
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_pixel"}, out_pixel, 0);
        check({tag, "_out_last"}, out_last, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_in_ready"}, in_ready, 0);
    endtask

    task automatic run_frame(input int t, input logic [1:0] m, input int chg_idx,
                             input logic [1:0] m2, input bit rnd, input bit drop);
        int g;
        frame_outs = 0;
        done_cnt = 0;
        first_valid_cyc = -1;
        rand_ready = rnd;
        mode = m;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r * W + c == chg_idx) mode = m2;
                if (drop && r * W + c == 30) begin
                    enable = 1'b0;
                    repeat (5) @(posedge clk);
                    #1 enable = 1'b1;
                end
                send_pixel(pix(t, r, c));
                if (r >= 2 && c >= 2) exp_q.push_back(expv(t, r - 1, c - 1));
                if (r == 2 && c == 2) acc_cyc = cyc;
                if (r == 5 && c == 0) check("busy_mid", busy, 1);
            end
        end
        in_valid = 1'b0;
        g = 0;
        while (done_cnt == 0 && g < 500) begin
            @(posedge clk);
            g++;
        end
        repeat (5) @(posedge clk);
        #1;
        if (t == 1) check("latency", first_valid_cyc - acc_cyc, 2);
        check("out_count", frame_outs, NOUT);
        check("done_pulses", done_cnt, 1);
        check("busy_after", busy, 0);
        check("queue_empty", exp_q.size(), 0);
        check("valid_after", out_valid, 0);
        rand_ready = 1'b0;
    endtask

    initial begin
        #1;
        check_reset_state("por");
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        run_frame(1, 2'd1, -1, 2'd1, 1'b0, 1'b0);
        run_frame(2, 2'd1, -1, 2'd1, 1'b0, 1'b0);
        run_frame(3, 2'd1, -1, 2'd1, 1'b0, 1'b0);
        run_frame(4, 2'd2, 10, 2'd1, 1'b0, 1'b0);
        run_frame(5, 2'd0, 1, 2'd3, 1'b1, 1'b1);

        // Partial frame abandoned by a reset after 20 accepted pixels.
        ignore_out = 1'b1;
        mode = 2'd3;
        for (int i = 0; i < 20; i++) send_pixel(8'($urandom_range(0, 255)));
        reset = 1'b1;
        #1;
        check_reset_state("mid_reset");
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        ignore_out = 1'b0;
        @(posedge clk);
        #1;
        run_frame(6, 2'd3, -1, 2'd3, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
